// File: rtl/mem_arbiter.sv
// Two-port (instruction/data cache) arbiter in front of a single line-wide physical memory port.
// Round-robin on ties; each transaction is captured at grant and followed by one DONE cycle.
module mem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                  state_q,  state_d;
    logic                    last_d_q, last_d_d;   // 1: D port was served last
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q,  wdata_d;
    logic                    write_q,  write_d;

    logic i_pend;
    logic d_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        i_rdata      = '0;
        d_resp       = 1'b0;
        d_rdata      = '0;
        i_pend       = i_read;
        d_pend       = d_read | d_write;

        unique case (state_q)
            IDLE: begin
                // D wins when it is alone, or on a tie when I was served last
                if (d_pend && (!i_pend || !last_d_q)) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = d_address;
                    wdata_d  = d_wdata;
                    write_d  = d_write;
                end else if (i_pend) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = i_address;
                    wdata_d  = '0;
                    write_d  = 1'b0;
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = addr_q;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = pmem_rdata;
                    state_d = DONE;
                end
            end
            SERVE_D: begin
                pmem_read    = ~write_q;
                pmem_write   = write_q;
                pmem_address = addr_q;
                pmem_wdata   = wdata_q;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    if (!write_q) begin
                        d_rdata = pmem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model with a behavioural memory.
module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [LW-1:0] mem [logic [AW-1:0]];
    int            mem_cnt = 0;
    logic [LW-1:0] pat_a;
    logic [LW-1:0] pat_b;

    // values observed by the last mem_step call
    logic          s_rd, s_wr, s_gave, s_ir, s_dr;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_wdata, s_ird, s_drd;

    mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    // Behavioural memory: one cycle per call, answers on the lat-th strobe cycle.
    task automatic mem_step(input int lat);
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = {8{$urandom}};
        s_rd = pmem_read; s_wr = pmem_write; s_addr = pmem_address; s_wdata = pmem_wdata;
        s_gave = 1'b0;
        if (s_rd || s_wr) begin
            mem_cnt++;
            if (mem_cnt >= lat) begin
                s_gave    = 1'b1;
                mem_cnt   = 0;
                pmem_resp = 1'b1;
                if (s_wr) mem[s_addr] = s_wdata;
                else      pmem_rdata  = mem_rd(s_addr);
            end
        end else begin
            mem_cnt = 0;
        end
        #1;
        s_ir = i_resp; s_dr = d_resp; s_ird = i_rdata; s_drd = d_rdata;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
        mem_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_read = 1'b1; d_read = 1'b1; d_write = 1'b1; pmem_resp = 1'b1;
        i_address = $urandom; d_address = $urandom; d_wdata = {8{$urandom}};
        pmem_rdata = {8{$urandom}};
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00", {pmem_read, pmem_write});
        end
        n_cmp++;
        if (pmem_address !== '0 || pmem_wdata !== '0) begin
            n_bad++; $display("FAIL reset_pmem_bus: got addr %h wdata %h want 0", pmem_address, pmem_wdata);
        end
        n_cmp++;
        if ({i_resp, d_resp} !== 2'b00) begin
            n_bad++; $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp});
        end
        n_cmp++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_bad++; $display("FAIL reset_rdata: got i %h d %h want 0", i_rdata, d_rdata);
        end
        do_reset();
        mem_step(1);
        n_cmp++;
        if ({s_rd, s_wr, s_ir, s_dr} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_idle_after_release: got %b want 0000", {s_rd, s_wr, s_ir, s_dr});
        end
    endtask

    task automatic test_single_i_read();
        int rd_cyc = 0, n_ir = 0, stray = 0, bad_addr = 0, first_rd = -1, resp_at = -1;
        logic [LW-1:0] got = '0;
        do_reset();
        mem[32'h40] = pat_a;
        i_read = 1'b1; i_address = 32'h0000_0040;
        for (int c = 0; c < 10; c++) begin
            mem_step(3);
            if (s_rd) begin
                rd_cyc++;
                if (first_rd < 0) first_rd = c;
                if (s_addr !== 32'h40) bad_addr++;
            end
            if (s_wr) bad_addr++;
            if (s_ir) begin
                n_ir++; got = s_ird; resp_at = c; i_read = 1'b0;
            end
            if (s_dr || s_drd !== '0) stray++;
        end
        n_cmp++;
        if (rd_cyc !== 3) begin n_bad++; $display("FAIL iread_strobe_cycles: got %0d want 3", rd_cyc); end
        n_cmp++;
        if (first_rd !== 0 || resp_at !== 2) begin
            n_bad++; $display("FAIL iread_timing: got strobe@%0d resp@%0d want 0/2", first_rd, resp_at);
        end
        n_cmp++;
        if (n_ir !== 1) begin n_bad++; $display("FAIL iread_resp_count: got %0d want 1", n_ir); end
        n_cmp++;
        if (got !== pat_a) begin n_bad++; $display("FAIL iread_rdata: got %h want %h", got, pat_a); end
        n_cmp++;
        if (stray !== 0 || bad_addr !== 0) begin
            n_bad++; $display("FAIL iread_side: got stray %0d badaddr %0d want 0/0", stray, bad_addr);
        end
    endtask

    task automatic test_tie_after_reset();
        int who [2];
        logic [AW-1:0] gaddr [2];
        int start [2];
        int rsp [2];
        int n_g = 0, n_r = 0;
        bit busy = 0;
        do_reset();
        i_read = 1'b1; i_address = 32'h100;
        d_read = 1'b1; d_address = 32'h200;
        for (int c = 0; c < 20 && n_r < 2; c++) begin
            mem_step(1);
            if ((s_rd || s_wr) && !busy) begin
                busy = 1; start[n_g] = c; gaddr[n_g] = s_addr; n_g++;
            end
            if (s_ir || s_dr) begin
                busy = 0; who[n_r] = s_dr ? 1 : 0; rsp[n_r] = c; n_r++;
                if (s_dr) d_read = 1'b0; else i_read = 1'b0;
            end
        end
        n_cmp++;
        if (n_r !== 2 || n_g !== 2) begin
            n_bad++; $display("FAIL tie_count: got %0d grants %0d resps want 2/2", n_g, n_r);
        end else begin
            n_cmp++;
            if (who[0] !== 1 || who[1] !== 0) begin
                n_bad++; $display("FAIL tie_order: got %0d,%0d want 1,0 (D then I)", who[0], who[1]);
            end
            n_cmp++;
            if (gaddr[0] !== 32'h200 || gaddr[1] !== 32'h100) begin
                n_bad++; $display("FAIL tie_addr: got %h,%h want 200,100", gaddr[0], gaddr[1]);
            end
            n_cmp++;
            if (start[1] - rsp[0] !== 3) begin
                n_bad++; $display("FAIL tie_gap: got %0d want 3", start[1] - rsp[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int who [4];
        int n_r = 0, bad_gap = 0, last_rsp = -100, lat;
        bit busy = 0;
        do_reset();
        i_read = 1'b1; i_address = 32'h1C0;
        d_read = 1'b1; d_address = 32'h2C0;
        lat = 2;
        for (int c = 0; c < 80 && n_r < 4; c++) begin
            mem_step(lat);
            if ((s_rd || s_wr) && !busy) begin
                busy = 1;
                if (n_r > 0 && c - last_rsp != 3) bad_gap++;
            end
            if (s_ir || s_dr) begin
                busy = 0; who[n_r] = s_dr ? 1 : 0; last_rsp = c; n_r++;
                lat = $urandom_range(1, 4);
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        n_cmp++;
        if (n_r !== 4) begin
            n_bad++; $display("FAIL b2b_count: got %0d want 4", n_r);
        end else begin
            n_cmp++;
            if (who[0] !== 1 || who[1] !== 0 || who[2] !== 1 || who[3] !== 0) begin
                n_bad++; $display("FAIL b2b_order: got %0d%0d%0d%0d want 1010 (D,I,D,I)",
                                  who[0], who[1], who[2], who[3]);
            end
        end
        n_cmp++;
        if (bad_gap !== 0) begin n_bad++; $display("FAIL b2b_gap: got %0d bad gaps want 0", bad_gap); end
    endtask

    task automatic test_d_write();
        int n_st = 0, bad = 0, n_dr = 0, n_ir = 0;
        do_reset();
        d_write = 1'b1; d_address = 32'h80; d_wdata = pat_b;
        for (int c = 0; c < 12; c++) begin
            mem_step(4);
            if (s_rd || s_wr) begin
                n_st++;
                if (!(s_wr && !s_rd && s_addr == 32'h80 && s_wdata == pat_b)) bad++;
                d_address = 32'h9999_0000; d_wdata = ~pat_b;
            end
            if (s_dr) begin n_dr++; d_write = 1'b0; end
            if (s_ir) n_ir++;
        end
        n_cmp++;
        if (n_st !== 4) begin n_bad++; $display("FAIL dwrite_strobe_cycles: got %0d want 4", n_st); end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL dwrite_bus: got %0d bad cycles want 0", bad); end
        n_cmp++;
        if (n_dr !== 1 || n_ir !== 0) begin
            n_bad++; $display("FAIL dwrite_resp: got d %0d i %0d want 1/0", n_dr, n_ir);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        do_reset();
        d_read = 1'b1; d_address = 32'h300;
        mem_step(100);
        mem_step(100);
        n_cmp++;
        if (s_rd !== 1'b1) begin n_bad++; $display("FAIL rstmid_serving: got %b want 1", s_rd); end
        #2;
        rst_n = 1'b0; d_read = 1'b0;
        #1;
        n_cmp++;
        if ({pmem_read, pmem_write, d_resp, i_resp} !== 4'b0000 || pmem_address !== '0
            || pmem_wdata !== '0 || d_rdata !== '0 || i_rdata !== '0) begin
            n_bad++; $display("FAIL rstmid_async_outputs: got strobes %b addr %h want all 0",
                              {pmem_read, pmem_write}, pmem_address);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pmem_resp = 1'b1; pmem_rdata = {8{$urandom}};
            #1;
            if (d_resp || i_resp || pmem_read || pmem_write) stray++;
        end
        pmem_resp = 1'b0;
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL rstmid_late_resp: got %0d stray cycles want 0", stray); end
    endtask

    task automatic test_spurious_resp();
        int stray = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pmem_resp = 1'b1; pmem_rdata = {8{$urandom}};
            #1;
            if (d_resp || i_resp || pmem_read || pmem_write || i_rdata !== '0 || d_rdata !== '0) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL spurious_idle: got %0d stray cycles want 0", stray); end
        i_read = 1'b1; i_address = 32'h500;
        mem_step(1);
        n_cmp++;
        if ({s_rd, s_ir} !== 2'b11 || s_addr !== 32'h500 || s_ird !== mem_rd(32'h500)) begin
            n_bad++; $display("FAIL spurious_then_grant: got rd %b resp %b addr %h want 1 1 500",
                              s_rd, s_ir, s_addr);
        end
        i_read = 1'b0;
        mem_step(1);
    endtask

    task automatic test_random();
        int done_txn = 0, lat, since = 99, gnt_port = 0;
        bit in_txn = 0, exp_gnt = 0, last_d = 0, pi = 0, pd = 0, dq_wr = 0, ex_wr = 0;
        bit exp_ir, exp_dr, strobe;
        logic [AW-1:0] iq_addr = '0, dq_addr = '0, ex_addr = '0;
        logic [LW-1:0] dq_wdata = '0, ex_wdata = '0, exp_ird, exp_drd;
        int mode;
        do_reset();
        lat = $urandom_range(1, 4);
        for (int cyc = 0; cyc < 4000 && done_txn < 40; cyc++) begin
            mem_step(lat);
            since++;
            strobe = s_rd | s_wr;
            if (!in_txn) begin
                n_cmp++;
                if (strobe !== exp_gnt) begin
                    n_bad++; $display("FAIL rand_grant_timing: got strobe %b want %b (cycle %0d)",
                                      strobe, exp_gnt, cyc);
                end
                if (strobe) begin
                    if (pi && pd) gnt_port = last_d ? 0 : 1;
                    else          gnt_port = pd ? 1 : 0;
                    last_d   = (gnt_port == 1);
                    ex_addr  = gnt_port == 1 ? dq_addr : iq_addr;
                    ex_wr    = (gnt_port == 1) && dq_wr;
                    ex_wdata = dq_wdata;
                    in_txn   = 1;
                    if (gnt_port == 1) begin
                        d_address = $urandom; d_wdata = {8{$urandom}};
                        d_read = dq_wr; d_write = !dq_wr;
                    end else begin
                        i_address = $urandom;
                    end
                end
            end
            if (in_txn) begin
                n_cmp++;
                if ({s_rd, s_wr} !== {!ex_wr, ex_wr} || s_addr !== ex_addr || (ex_wr && s_wdata !== ex_wdata)) begin
                    n_bad++; $display("FAIL rand_pmem_bus: got rd %b wr %b addr %h want rd %b wr %b addr %h",
                                      s_rd, s_wr, s_addr, !ex_wr, ex_wr, ex_addr);
                end
            end
            exp_ir  = in_txn && s_gave && gnt_port == 0;
            exp_dr  = in_txn && s_gave && gnt_port == 1;
            exp_ird = exp_ir ? mem_rd(ex_addr) : '0;
            exp_drd = (exp_dr && !ex_wr) ? mem_rd(ex_addr) : '0;
            n_cmp++;
            if ({s_ir, s_dr} !== {exp_ir, exp_dr} || s_ird !== exp_ird
                || (!(exp_dr && ex_wr) && s_drd !== exp_drd)) begin
                n_bad++; $display("FAIL rand_resp: got i %b d %b want i %b d %b (cycle %0d)",
                                  s_ir, s_dr, exp_ir, exp_dr, cyc);
            end
            if (in_txn && s_gave) begin
                $display("txn %0d: port %s %s addr=%h lat=%0d", done_txn, gnt_port == 1 ? "D" : "I",
                         ex_wr ? "write" : "read", ex_addr, lat);
                in_txn = 0; since = 0; done_txn++;
                lat = $urandom_range(1, 4);
                if (gnt_port == 1) begin pd = 0; d_read = 1'b0; d_write = 1'b0; end
                else               begin pi = 0; i_read = 1'b0; end
            end
            if (!pi && $urandom_range(0, 2) == 0) begin
                pi = 1; iq_addr = AW'($urandom_range(0, 7)) << 6;
                i_read = 1'b1; i_address = iq_addr;
            end
            if (!pd && $urandom_range(0, 2) == 0) begin
                pd = 1; mode = $urandom_range(0, 2); dq_wr = (mode != 0);
                dq_addr = AW'($urandom_range(0, 7)) << 6; dq_wdata = {8{$urandom}};
                d_read = (mode != 1); d_write = (mode != 0);
                d_address = dq_addr; d_wdata = dq_wdata;
            end
            exp_gnt = !in_txn && since >= 2 && (pi || pd);
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        n_cmp++;
        if (done_txn !== 40) begin n_bad++; $display("FAIL rand_completed: got %0d want 40", done_txn); end
    endtask

    initial begin
        pat_a = {8{32'hA5A5_0F0F}};
        pat_b = {8{32'h3C3C_1234}};
        test_reset();
        test_single_i_read();
        test_tie_after_reset();
        test_back_to_back();
        test_d_write();
        test_reset_mid();
        test_spurious_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
